cia_timer_bank: RTL
===================

// Module: cia_timer_bank
// PURPOSE
// - Parametrised bank of NTIMERS down-counting interval timers for CIA-style cores; successor to fixed two-timer TA/TB pair.
// - Generic WIDTH, per-channel input select incl. cascade from previous channel, pulse/toggle output, one-shot, per-channel IRQ enable.
// - Sits beside cia_interrupt: drives intr[] into ICR sources and tout[] into port PB muxing.
// PARAMETERS
// - NTIMERS  4   number of timer channels (1..8)
// - WIDTH    16  counter/latch width in bits; one of 8, 16, 24
// - AW       $clog2(NTIMERS)+2  register address width (derived; do not override)
// PORTS
// - clk      in   1        FPGA clock
// - rst      in   1        synchronous, active-high reset
// - phi2_dn  in   1        PHI2 falling-edge strobe, one clk wide; all state updates occur only in this cycle
// - we       in   1        write enable (level while PHI2 high and selected)
// - addr     in   AW       {channel, byte}; byte 0..2 = latch/counter bytes LSB first, byte 3 = control
// - data     in   8        write data
// - cnt_up   in   1        CNT rising-edge event, aligned to phi2_dn
// - cnt      in   1        CNT pad level
// - rdata    out  8        read data of addressed register, combinational
// - ufl      out  NTIMERS  underflow pulse per channel, one clk wide (coincident with phi2_dn)
// - intr     out  NTIMERS  ufl & ien per channel, combinational
// - tout     out  NTIMERS  timer output per channel (PB level)
// BEHAVIOUR
// - Reset: latch = all ones, counter = all ones, control = 0, tout = 0; ufl/intr = 0; rdata follows regs.
// - Control byte: [0] start, [1] outmode (0 pulse, 1 toggle), [2] oneshot, [3] force load (strobe, reads 0),
//   [5:4] inmode (00 phi2, 01 cnt_up, 10 ufl[i-1], 11 ufl[i-1] & cnt), [6] ien, [7] reserved (reads 0, write ignored).
// - Tick(i) = start & phi2_dn & source(inmode); channel 0 in modes 10/11 never ticks.
// - Cascade is combinational within one phi2_dn cycle: ufl[i-1] ticks channel i in the same clk.
// - On tick: counter == 0 -> ufl=1, counter <= latch; else counter <= counter-1.
// - One-shot: underflow clears start in the same update.
// - Reads: bytes 0..WIDTH/8-1 return counter bytes; bytes >= WIDTH/8 (<3) read 0.
// - Writes commit on we & phi2_dn: latch bytes write latch only.
// - Writing the top latch byte (byte WIDTH/8-1) while start=0 (before this write) also loads counter <= new latch.
// - Control write with force load: counter <= latch.
// - Precedence, same cycle, one channel: force load > top-byte load > tick (no ufl, no decrement).
// - CPU control write with start=1 overrides one-shot clear.
// - Byte writes to >= WIDTH/8 latch slots: ignored.
// - tout pulse mode: tout = 1 from underflow until next phi2_dn without underflow (one PHI2 cycle).
// - tout toggle mode: tout flips on each underflow; tout <= 1 on a write that sets start 0->1.
// - Arithmetic: WIDTH-bit unsigned, wraps only via reload; latch = 0 -> underflow on every tick.
// - rst mid-count: all channels return to reset values next clk; no ufl emitted in the reset cycle.
// STRUCTURE
// - Shared package cia: tbctrl_t packed struct (control byte), tbinmode_t enum {TB_PHI2, TB_CNT, TB_CASC, TB_CASC_CNT},
//   tbregs_t (latch, counter, ctrl) for debug/trace.
// - Sub-module cia_timer_ch: one channel (latch, counter, control, tout). Instantiated NTIMERS times via generate;
//   ufl chain wired between instances; bank does address decode and rdata mux.
// TESTING
// - Reset, read all regs -> counter bytes 0xFF, control 0x00, tout=0, ufl=0.
// - ch0 latch=0x0003, ctrl=0x01 (phi2 continuous) -> ufl[0] every 4th phi2_dn; counter reads 3,2,1,0,3.
// - ch0 latch=0x0001 continuous; ch1 latch=0x0002, inmode=10, start -> ufl[1] same clk as every 3rd ufl[0].
// - ch2 oneshot, latch=5 -> single ufl[2] after 6 ticks, start reads 0, counter=5, no further ufl.
// - Toggle mode, latch=1, start write -> tout=1, then 0,1,0 flipping every 2 ticks; pulse mode -> tout high 1 PHI2 cycle per ufl.
// - Force load on the cycle counter==0 -> counter=latch, ufl=0.
// - Top-byte write while stopped -> counter=new latch; same write while running -> counter unchanged.
// - ien=1 -> intr[i]=ufl[i]; ien=0 -> intr[i]=0.
// - WIDTH=24, NTIMERS=8 build: byte 2 R/W; WIDTH=8: bytes 1..2 read 0 and ignore writes.
// - Assert rst mid-count -> next clk counter=0xFFFF, ctrl=0, tout=0.

Source files
------------

// File: rtl/cia_timer_bank_pkg.sv
// cia_timer_bank_pkg: shared control-byte layout and register types for the CIA timer bank
package cia_timer_bank_pkg;
    typedef enum logic [1:0] {TB_PHI2, TB_CNT, TB_CASC, TB_CASC_CNT} tbinmode_t;
    typedef struct packed {
        logic      rsvd;
        logic      ien;
        tbinmode_t inmode;
        logic      load;
        logic      oneshot;
        logic      outmode;
        logic      start;
    } tbctrl_t;
    typedef struct packed {
        logic [23:0] latch;
        logic [23:0] counter;
        tbctrl_t     ctrl;
    } tbregs_t;
    localparam logic [1:0] CTRL_BYTE = 2'd3;
endpackage

// File: rtl/cia_timer_bank_if.sv
// cia_timer_bank_if: CPU register bus of the timer bank
interface cia_timer_bank_if #(parameter int NTIMERS = 4);
    localparam int AW = $clog2(NTIMERS) + 2;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [7:0]    rdata;
    modport master (output we, addr, data, input rdata);
    modport slave (input we, addr, data, output rdata);
endinterface

// File: rtl/cia_timer_bank_ch.sv
// cia_timer_bank_ch: one down-counting interval timer channel with latch, control byte and tout
module cia_timer_bank_ch import cia_timer_bank_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       phi2_dn_i,
    input  logic       we_i,
    input  logic [1:0] byte_i,
    input  logic [7:0] data_i,
    input  logic       cnt_up_i,
    input  logic       cnt_i,
    input  logic       casc_i,
    output logic       ufl_o,
    output logic       intr_o,
    output logic       tout_o,
    output logic [7:0] rd_o
);
    localparam int NB = WIDTH / 8;
    logic [WIDTH-1:0] latch_q, latch_d, cnt_q, cnt_d;
    tbctrl_t ctrl_q, ctrl_d, wr_ctrl;
    logic tout_q, tout_d, wr, ctrl_wr, force_ld, top_ld, src, tick;
    always_comb begin
        wr = we_i & phi2_dn_i;
        wr_ctrl = tbctrl_t'(data_i);
        wr_ctrl.rsvd = 1'b0;
        wr_ctrl.load = 1'b0;
        ctrl_wr = wr & (byte_i == CTRL_BYTE);
        force_ld = ctrl_wr & data_i[3];
        top_ld = wr & (byte_i == 2'(NB - 1)) & ~ctrl_q.start;
        latch_d = latch_q;
        rd_o = byte_i == CTRL_BYTE ? 8'(ctrl_q) : 8'h00;
        for (int b = 0; b < NB; b++) begin
            if (wr && byte_i == 2'(b)) latch_d[b*8 +: 8] = data_i;
            if (byte_i == 2'(b)) rd_o = cnt_q[b*8 +: 8];
        end
        src = ctrl_q.inmode == TB_PHI2 ? 1'b1 : ctrl_q.inmode == TB_CNT ? cnt_up_i :
              ctrl_q.inmode == TB_CASC ? casc_i : casc_i & cnt_i;
        // loads pre-empt the tick entirely: no decrement and no underflow
        tick = ctrl_q.start & phi2_dn_i & src & ~force_ld & ~top_ld & ~rst;
        ufl_o = tick & (cnt_q == '0);
        intr_o = ufl_o & ctrl_q.ien;
        cnt_d = force_ld ? latch_q : top_ld ? latch_d : ufl_o ? latch_q : tick ? cnt_q - WIDTH'(1) : cnt_q;
        ctrl_d = ctrl_wr ? wr_ctrl : ctrl_q;
        ctrl_d.start = ctrl_wr ? wr_ctrl.start : ctrl_q.start & ~(ufl_o & ctrl_q.oneshot);
        tout_d = ~phi2_dn_i ? tout_q : (ctrl_wr & wr_ctrl.start & ~ctrl_q.start & wr_ctrl.outmode) ? 1'b1 :
                 ctrl_q.outmode ? tout_q ^ ufl_o : ufl_o;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q <= '1;
            cnt_q <= '1;
            ctrl_q <= '0;
            tout_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            cnt_q <= cnt_d;
            ctrl_q <= ctrl_d;
            tout_q <= tout_d;
        end
    end
    assign tout_o = tout_q;
endmodule

// File: rtl/cia_timer_bank.sv
// cia_timer_bank: NTIMERS cascadable CIA-style interval timers with address decode and read mux
module cia_timer_bank import cia_timer_bank_pkg::*; #(
    parameter int NTIMERS = 4,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(NTIMERS) + 2
) (
    input  logic               clk,
    input  logic               rst,
    cia_timer_bank_if.slave    bus,
    input  logic               phi2_dn_i,
    input  logic               cnt_up_i,
    input  logic               cnt_i,
    output logic [NTIMERS-1:0] ufl_o,
    output logic [NTIMERS-1:0] intr_o,
    output logic [NTIMERS-1:0] tout_o
);
    logic [AW-1:0] addr;
    logic [3:0] ch_sel;
    logic [7:0] rd [NTIMERS];
    assign addr = bus.addr;
    assign ch_sel = 4'(addr >> 2);
    for (genvar i = 0; i < NTIMERS; i++) begin : ch_g
        // separate per-channel nets keep the combinational ufl cascade acyclic
        logic u, casc;
        if (i == 0) begin : g_first
            assign casc = 1'b0;
        end else begin : g_next
            assign casc = ch_g[i-1].u;
        end
        cia_timer_bank_ch #(.WIDTH(WIDTH)) u_ch (
            .clk(clk),
            .rst(rst),
            .phi2_dn_i(phi2_dn_i),
            .we_i(bus.we & (ch_sel == 4'(i))),
            .byte_i(addr[1:0]),
            .data_i(bus.data),
            .cnt_up_i(cnt_up_i),
            .cnt_i(cnt_i),
            .casc_i(casc),
            .ufl_o(u),
            .intr_o(intr_o[i]),
            .tout_o(tout_o[i]),
            .rd_o(rd[i])
        );
        assign ufl_o[i] = u;
    end
    always_comb begin
        bus.rdata = 8'h00;
        for (int k = 0; k < NTIMERS; k++)
            if (ch_sel == 4'(k)) bus.rdata = rd[k];
    end
endmodule
